// File: rtl/c499_key_pkg.sv
// Shared constants, FSM state type and CRC-5 step for the c499 key loader.
// Build option: C499_KEY_CRC_EN appends a 5-bit CRC to the serial key.
package c499_key_pkg;

  localparam int unsigned KEY_W = 20;
  localparam int unsigned CRC_W = 5;
  localparam logic [CRC_W-1:0] CRC_POLY = 5'b00101;
  localparam logic [CRC_W-1:0] CRC_INIT = 5'b11111;

`ifdef C499_KEY_CRC_EN
  localparam int unsigned SH_W       = KEY_W + CRC_W;
  localparam int unsigned CHK_CYCLES = KEY_W;
`else
  localparam int unsigned SH_W       = KEY_W;
  localparam int unsigned CHK_CYCLES = 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOCKED,
    ERROR
  } state_t;

  // One MSB-first step of x^5+x^2+1.
  function automatic logic [CRC_W-1:0] crc5_next(input logic [CRC_W-1:0] crc,
                                                  input logic din);
    crc5_next = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ din) ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/c499_key_loader_if.sv
// Key loader control/status bundle between the system side and the loader.
interface c499_key_loader_if;
  import c499_key_pkg::*;

  logic             key_sin;
  logic             key_sen;
  logic             key_commit;
  logic             key_clear;
  logic             ecc_en_req;
  logic [KEY_W-1:0] key;
  logic             ecc_en;
  logic             key_valid;
  logic             key_err;
  logic             busy;

  modport master (
    output key_sin, key_sen, key_commit, key_clear, ecc_en_req,
    input  key, ecc_en, key_valid, key_err, busy
  );

  modport slave (
    input  key_sin, key_sen, key_commit, key_clear, ecc_en_req,
    output key, ecc_en, key_valid, key_err, busy
  );

endinterface

// File: rtl/c499_key_loader_crc5_serial.sv
// Serial CRC-5 (x^5+x^2+1) register, one message bit per enabled cycle.
module crc5_serial
  import c499_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (init) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc5_next(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/c499_key_loader.sv
// Serial key loader for the c499 corrector: shift, check, lock, drive key/enable.
// Build option: C499_KEY_CRC_EN enables the 20-cycle CRC-5 check of 5 trailing bits.
module c499_key_loader
  import c499_key_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  c499_key_loader_if.slave   bus
);

  state_t            r_state;
  logic [SH_W-1:0]   r_shreg;
  logic [4:0]        r_cnt;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_valid;
  logic              r_key_err;
  logic              r_busy;
  logic              r_ecc_en;

  logic              w_cnt_full;
  logic              w_chk_done;
  logic              w_chk_pass;

  assign w_cnt_full = (r_cnt == 5'(SH_W));

`ifdef C499_KEY_CRC_EN
  logic [4:0]        r_chk;
  logic [4:0]        w_bit_idx;
  logic [CRC_W-1:0]  w_crc;
  logic              w_crc_init;
  logic              w_crc_en;
  logic              w_crc_din;

  // CRC register is seeded on the accepted commit so CHECK can feed bits immediately.
  assign w_crc_init = (r_state == SHIFT) && bus.key_commit && !bus.key_clear && w_cnt_full;
  assign w_crc_en   = (r_state == CHECK);
  assign w_bit_idx  = 5'(SH_W - 1) - r_chk;
  assign w_crc_din  = r_shreg[w_bit_idx];

  crc5_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (w_crc_init),
    .en    (w_crc_en),
    .din   (w_crc_din),
    .crc   (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (r_state != CHECK || bus.key_clear) begin
      r_chk <= '0;
    end else begin
      r_chk <= r_chk + 5'd1;
    end
  end

  // Last bit is folded in combinationally so the verdict lands on cycle 20.
  assign w_chk_done = (r_chk == 5'(CHK_CYCLES - 1));
  assign w_chk_pass = (crc5_next(w_crc, w_crc_din) == r_shreg[CRC_W-1:0]);
`else
  assign w_chk_done = 1'b1;
  assign w_chk_pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_ecc_en    <= 1'b0;
    end else if (bus.key_clear) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_ecc_en    <= 1'b0;
    end else begin
      r_ecc_en <= bus.ecc_en_req & r_key_valid;
      case (r_state)
        IDLE, SHIFT: begin
          if (bus.key_commit) begin
            if (r_state == SHIFT && w_cnt_full) begin
              r_state <= CHECK;
              r_busy  <= 1'b1;
            end else begin
              r_state   <= ERROR;
              r_key_err <= 1'b1;
            end
          end else if (bus.key_sen) begin
            r_shreg <= {r_shreg[SH_W-2:0], bus.key_sin};
            r_cnt   <= (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
            r_state <= SHIFT;
          end
        end
        CHECK: begin
          if (w_chk_done) begin
            r_busy <= 1'b0;
            if (w_chk_pass) begin
              r_state     <= LOCKED;
              r_key       <= r_shreg[SH_W-1 -: KEY_W];
              r_key_valid <= 1'b1;
            end else begin
              r_state   <= ERROR;
              r_key_err <= 1'b1;
            end
          end
        end
        LOCKED, ERROR: begin
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.key_err   = r_key_err;
  assign bus.busy      = r_busy;
  assign bus.ecc_en    = r_ecc_en;

endmodule

// File: tb/tb_c499_key_loader.sv
// Self-checking bench for c499_key_loader against a transaction-level reference model.
module tb_c499_key_loader;
  import c499_key_pkg::*;

`ifdef C499_KEY_CRC_EN
  localparam int NB      = 25;
  localparam int CHK_LEN = 20;
`else
  localparam int NB      = 20;
  localparam int CHK_LEN = 1;
`endif
  localparam logic [31:0] MASK = (32'd1 << NB) - 32'd1;

  localparam int M_IDLE = 0, M_SHIFT = 1, M_CHECK = 2, M_LOCKED = 3, M_ERROR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  c499_key_loader_if bus();

  c499_key_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int          m_mode = M_IDLE;
  logic [31:0] m_bits = '0;
  int          m_cnt  = 0;
  int          m_rem  = 0;
  logic        m_ecc  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // CRC as polynomial remainder of (init*x^20 + msg*x^5) mod (x^5+x^2+1).
  function automatic logic [4:0] ref_crc(input logic [19:0] msg);
    logic [24:0] v;
    v = {msg, 5'b0} ^ {5'b11111, 20'b0};
    for (int i = 24; i >= 5; i--)
      if (v[i]) v = v ^ (25'b100101 << (i - 5));
    return v[4:0];
  endfunction

  function automatic logic [31:0] make_word(input logic [19:0] k, input logic good);
`ifdef C499_KEY_CRC_EN
    logic [4:0] c;
    c = ref_crc(k) ^ (good ? 5'b00000 : 5'b00001);
    return {7'b0, k, c};
`else
    return {12'b0, k};
`endif
  endfunction

  function automatic logic crc_ok(input logic [31:0] b);
`ifdef C499_KEY_CRC_EN
    return ref_crc(b[24:5]) == b[4:0];
`else
    return b == b;
`endif
  endfunction

  task automatic model_step();
    logic old_valid;
    old_valid = (m_mode == M_LOCKED);
    if (bus.key_clear) begin
      m_mode = M_IDLE; m_bits = '0; m_cnt = 0; m_ecc = 1'b0;
    end else begin
      m_ecc = bus.ecc_en_req && old_valid;
      if (m_mode == M_IDLE || m_mode == M_SHIFT) begin
        if (bus.key_commit) begin
          if (m_mode == M_SHIFT && m_cnt == NB) begin
            m_mode = M_CHECK; m_rem = CHK_LEN;
          end else begin
            m_mode = M_ERROR;
          end
        end else if (bus.key_sen) begin
          m_bits = ((m_bits << 1) | {31'b0, bus.key_sin}) & MASK;
          if (m_cnt < 31) m_cnt++;
          m_mode = M_SHIFT;
        end
      end else if (m_mode == M_CHECK) begin
        if (m_rem == 1) m_mode = crc_ok(m_bits) ? M_LOCKED : M_ERROR;
        else m_rem--;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_bits = '0; m_cnt = 0; m_rem = 0; m_ecc = 1'b0;
  endtask

  task automatic compare();
    logic [31:0] ek;
    ek = (m_mode == M_LOCKED) ? ((m_bits >> (NB - 20)) & 32'hFFFFF) : 32'h0;
    check("key",       32'(bus.key),       ek);
    check("key_valid", 32'(bus.key_valid), 32'(m_mode == M_LOCKED));
    check("key_err",   32'(bus.key_err),   32'(m_mode == M_ERROR));
    check("busy",      32'(bus.busy),      32'(m_mode == M_CHECK));
    check("ecc_en",    32'(bus.ecc_en),    32'(m_ecc));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic quiet();
    bus.key_sin = 1'b0; bus.key_sen = 1'b0; bus.key_commit = 1'b0; bus.key_clear = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.key_sen = 1'b1; bus.key_sin = w[i];
      cyc();
    end
    bus.key_sen = 1'b0; bus.key_sin = 1'b0;
  endtask

  task automatic do_commit();
    bus.key_commit = 1'b1; cyc(); bus.key_commit = 1'b0;
  endtask

  task automatic do_clear();
    bus.key_clear = 1'b1; cyc(); bus.key_clear = 1'b0;
  endtask

  task automatic wait_check_done(output int bc);
    bc = bus.busy ? 1 : 0;
    for (int i = 0; i < CHK_LEN + 5 && bus.busy; i++) begin
      cyc();
      if (bus.busy) bc++;
    end
  endtask

  initial begin
    int bc;
    logic [31:0] w;
    int k;

    rst_n = 1'b0;
    quiet();
    bus.ecc_en_req = 1'b0;
    #12;
    compare();
    rst_n = 1'b1;

    // Golden key, first bit accepted straight out of reset.
    w = make_word(20'hA5C3F, 1'b1);
    shift_word(w, NB);
    do_commit();
    check("busy_after_commit", 32'(bus.busy), 32'd1);
    wait_check_done(bc);
    check("busy_len", 32'(bc), 32'(CHK_LEN));
    check("locked_key", 32'(bus.key), 32'hA5C3F);
    check("locked_valid", 32'(bus.key_valid), 32'd1);
    check("locked_err", 32'(bus.key_err), 32'd0);

    bus.ecc_en_req = 1'b1;
    cyc();
    check("ecc_en_latency", 32'(bus.ecc_en), 32'd1);
    for (int i = 0; i < 30; i++) begin
      bus.key_sen = 1'($urandom); bus.key_sin = 1'($urandom);
      bus.key_commit = ($urandom_range(0, 5) == 0);
      cyc();
    end
    quiet();
    cyc();
    check("locked_key_hold", 32'(bus.key), 32'hA5C3F);

    // Short key rejected.
    do_clear();
    check("clear_ecc_off", 32'(bus.ecc_en), 32'd0);
    bus.ecc_en_req = 1'b0;
    shift_word($urandom, NB - 1);
    do_commit();
    check("short_err", 32'(bus.key_err), 32'd1);
    check("short_key", 32'(bus.key), 32'd0);
    do_clear();
    check("clear_err", 32'(bus.key_err), 32'd0);
    check("clear_valid", 32'(bus.key_valid), 32'd0);
    check("clear_busy", 32'(bus.busy), 32'd0);

    // Commit beats shift at full count.
    w = make_word(20'h3C96A, 1'b1);
    shift_word(w, NB);
    bus.key_commit = 1'b1; bus.key_sen = 1'b1; bus.key_sin = 1'b1;
    cyc();
    quiet();
    wait_check_done(bc);
    check("commit_wins_key", 32'(bus.key), 32'h3C96A);
    do_clear();

`ifdef C499_KEY_CRC_EN
    w = make_word(20'hA5C3F, 1'b0);
    shift_word(w, NB);
    do_commit();
    wait_check_done(bc);
    check("bad_crc_err", 32'(bus.key_err), 32'd1);
    check("bad_crc_valid", 32'(bus.key_valid), 32'd0);
    do_clear();
`endif

    // Randomised sessions.
    for (int s = 0; s < 40; s++) begin
      do_clear();
      k = NB + $urandom_range(0, 3) - 1;
      if (k > NB + 1) k = NB;
      bus.ecc_en_req = 1'($urandom);
      shift_word(make_word(20'($urandom), 1'($urandom)), k);
      if ($urandom_range(0, 3) != 0) begin
        bus.key_commit = 1'b1; bus.key_sen = 1'($urandom); bus.key_sin = 1'($urandom);
        cyc();
        quiet();
      end
      for (int i = 0; i < CHK_LEN + 10; i++) begin
        bus.key_sen = 1'($urandom); bus.key_sin = 1'($urandom);
        bus.key_commit = ($urandom_range(0, 7) == 0);
        bus.key_clear = ($urandom_range(0, 40) == 0);
        bus.ecc_en_req = 1'($urandom);
        cyc();
      end
      quiet();
    end

    // Asynchronous reset in the middle of CHECK.
    do_clear();
    bus.ecc_en_req = 1'b1;
    shift_word(make_word(20'hA5C3F, 1'b1), NB);
    do_commit();
    if (CHK_LEN > 2) begin
      cyc(); cyc();
    end
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_key", 32'(bus.key), 32'd0);
    check("rst_valid", 32'(bus.key_valid), 32'd0);
    check("rst_err", 32'(bus.key_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ecc", 32'(bus.ecc_en), 32'd0);
    model_reset();
    #3;
    rst_n = 1'b1;
    shift_word(make_word(20'h0F0F1, 1'b1), NB);
    do_commit();
    wait_check_done(bc);
    check("post_reset_key", 32'(bus.key), 32'h0F0F1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c499_key_loader.md
C499_KEY_LOADER -- requirements
Module: c499_key_loader

Interface
REQ-001 The block SHALL use the port `clk`, input, 1 bit, as its single clock; every state element SHALL be rising-edge triggered.
REQ-002 The block SHALL use the port `rst_n`, input, 1 bit, as its reset: asynchronous and active-low.
REQ-003 `key_sin`, input, 1 bit: serial key data, MSB first.
REQ-004 `key_sen`, input, 1 bit: shift enable; one bit is accepted per cycle while high.
REQ-005 `key_commit`, input, 1 bit: single-cycle request to check and apply the shifted key.
REQ-006 `key_clear`, input, 1 bit: synchronous return to IDLE from any state.
REQ-007 `ecc_en_req`, input, 1 bit: system request to enable correction.
REQ-008 `key`, output, 20 bits: drives the corrector key inputs p1..p20; bit 19 drives p1.
REQ-009 `ecc_en`, output, 1 bit: drives the corrector enable input N137.
REQ-010 `key_valid`, `key_err` and `busy`, outputs, 1 bit each: status flags.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SHIFT, CHECK, LOCKED and ERROR.
REQ-012 Input priority SHALL be: `key_clear` > `key_commit` > `key_sen`; any lower-priority input in the same cycle SHALL be discarded.
REQ-013 In IDLE or SHIFT, `key_sen`=1 SHALL do all of the following:
- shift `shreg <= {shreg[N-2:0], key_sin}`;
- increment the 5-bit bit counter, saturating at 31;
- enter SHIFT.
REQ-014 N SHALL be 20 without KEY_CRC_EN and 25 with it.
REQ-015 `key_commit` in SHIFT SHALL go to CHECK if the count equals N, and to ERROR otherwise.
REQ-016 `key_commit` in IDLE SHALL go to ERROR.
REQ-017 CHECK SHALL take 1 cycle without KEY_CRC_EN and 20 cycles with it, then go to LOCKED on pass or ERROR on fail.
REQ-018 In LOCKED, `key` SHALL equal `shreg[N-1:N-20]`, registered, and `key_valid` SHALL be 1; `key_sen` and `key_commit` SHALL be ignored.
REQ-019 In every state other than LOCKED, `key` SHALL be 0 and `key_valid` SHALL be 0; partial keys SHALL never be driven.
REQ-020 `ecc_en` SHALL equal `ecc_en_req & key_valid`, registered, giving 1-cycle latency.
REQ-021 `key_err` SHALL be 1 exactly in ERROR; ERROR SHALL exit only via `key_clear` or reset.
REQ-022 `busy` SHALL be 1 exactly in CHECK.
REQ-023 `key_clear` SHALL always do all of the following:
- go to IDLE;
- zero `shreg` and the counter;
- deassert `key` and `ecc_en` on the next edge, including when asserted mid-CHECK.

Reset
REQ-024 While `rst_n`=0, the FSM SHALL be in IDLE and all of the following SHALL be 0: `shreg`, counter, CRC register, `key`, `key_valid`, `key_err`, `busy`, `ecc_en`.
REQ-025 Reset deassertion SHALL require no extra initialisation cycle: the first `key_sen` after release SHALL be accepted.

Configuration
REQ-026 Macro C499_KEY_CRC_EN defined: 5 CRC bits SHALL follow the 20 key bits.
- CHECK SHALL compute CRC-5 with polynomial x^5+x^2+1 and init 5'b11111 serially over `shreg[24:5]`, MSB first, one bit per cycle.
- The check SHALL pass iff the result equals `shreg[4:0]`.
REQ-027 Macro absent: N SHALL be 20, no CRC logic SHALL be present, and CHECK SHALL always pass.

Structure
REQ-028 Package c499_key_pkg SHALL hold:
- KEY_W=20;
- CRC_W=5;
- CRC_POLY=5'b00101;
- CRC_INIT=5'b11111;
- the FSM state enum.
REQ-029 The serial CRC SHALL be a sub-module crc5_serial (ports: clk, rst_n, init, en, din, crc), instantiated only under C499_KEY_CRC_EN.

Verification
REQ-030 Without the macro: shift 20'hA5C3F, then commit -> `busy` is 1 for 1 cycle; then `key`=20'hA5C3F, `key_valid`=1, `key_err`=0.
REQ-031 Shift 19 bits, then commit -> ERROR, `key_err`=1, `key`=0; `key_clear` -> IDLE with all flags 0.
REQ-032 With the macro: shift 20'hA5C3F plus the correct CRC -> LOCKED after exactly 20 `busy` cycles.
REQ-033 With the macro: shift 20'hA5C3F plus (correct CRC ^ 5'b00001) -> ERROR.
REQ-034 LOCKED, then `ecc_en_req`=1 -> `ecc_en`=1 one cycle later; `key_sen` toggling with random bits leaves `key` unchanged.
REQ-035 `key_commit` and `key_sen` high in the same cycle at count 20 -> commit wins and the bit is dropped.
REQ-036 Assert `rst_n`=0 mid-CHECK -> all outputs are 0 immediately, asynchronously.
